// File: rtl/kbd_pkg.sv
// Shared types and helpers for the PS/2 host-to-device transmitter.
package kbd_pkg;

  localparam int PS2_FRAME_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_START     = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } tx_state_e;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Synchronises the raw PS/2 clock and data lines and flags ps2clk falling edges
// using an 8-sample history (four high samples followed by four low samples).
module ps2_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic ps2clk,
  input  logic ps2data,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic [1:0] clk_meta_q, clk_meta_d;
  logic [1:0] data_meta_q, data_meta_d;
  logic [7:0] sample_q, sample_d;

  always_comb begin
    clk_meta_d  = {clk_meta_q[0], ps2clk};
    data_meta_d = {data_meta_q[0], ps2data};
    sample_d    = {sample_q[6:0], clk_meta_q[1]};
  end

  // Idle PS/2 lines are high, so everything resets to ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_q  <= 2'b11;
      data_meta_q <= 2'b11;
      sample_q    <= 8'hFF;
    end else begin
      clk_meta_q  <= clk_meta_d;
      data_meta_q <= data_meta_d;
      sample_q    <= sample_d;
    end
  end

  assign clk_sync  = clk_meta_q[1];
  assign data_sync = data_meta_q[1];
  assign clk_fall  = (sample_q[7:4] == 4'hF) && (sample_q[3:0] == 4'h0);

endmodule

// File: rtl/kbd_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, start, 10 frame bits, ACK, idle).
// Define KBD_TX_ACK_CHECK_EN to turn a device NACK into an error pulse.
module kbd_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  input  logic [7:0] cmd,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       error
);
  import kbd_pkg::*;

  localparam int INH_W    = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BIT_W    = $clog2(PS2_FRAME_BITS + 1);
  localparam int INH_PRE_I = (INHIBIT_CYCLES >= 2) ? INHIBIT_CYCLES - 2 : 0;

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INH_PRE_I);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PS2_FRAME_BITS - 1);

  logic clk_sync, data_sync, clk_fall;

  ps2_edge_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .ps2clk   (ps2clk),
    .ps2data  (ps2data),
    .clk_sync (clk_sync),
    .data_sync(data_sync),
    .clk_fall (clk_fall)
  );

  tx_state_e                 state_q, state_d;
  logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
  logic [INH_W-1:0]          inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
  logic [BIT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic busy_q, busy_d, done_q, done_d, error_q, error_d;

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    bit_cnt_d = bit_cnt_q;
    clk_oe_d  = 1'b0;
    data_oe_d = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (send) begin
          frame_d   = {1'b1, odd_parity(cmd), cmd};
          inh_cnt_d = '0;
          to_cnt_d  = '0;
          busy_d    = 1'b1;
          clk_oe_d  = 1'b1;
          data_oe_d = (INHIBIT_CYCLES <= 1);
          state_d   = ST_INHIBIT;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_INHIBIT: begin
        // Data is pulled low one cycle before the clock is released.
        clk_oe_d  = 1'b1;
        data_oe_d = (inh_cnt_q >= INH_PRE);
        if (inh_cnt_q >= INH_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = ST_START;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
        end
      end
      ST_START: begin
        data_oe_d = 1'b1;
        bit_cnt_d = '0;
        to_cnt_d  = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (clk_fall) begin
          data_oe_d = ~frame_q[0];
          frame_d   = {1'b0, frame_q[PS2_FRAME_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          to_cnt_d  = '0;
          if (bit_cnt_q >= BIT_LAST) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_SHIFT;
          end
        end else if (to_cnt_q >= TO_LAST) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          data_oe_d = data_oe_q;
          to_cnt_d  = to_cnt_q + TO_W'(1);
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
`ifdef KBD_TX_ACK_CHECK_EN
          if (data_sync) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            to_cnt_d = '0;
            state_d  = ST_WAIT_IDLE;
          end
`else
          to_cnt_d = '0;
          state_d  = ST_WAIT_IDLE;
`endif
        end else if (to_cnt_q >= TO_LAST) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (to_cnt_q >= TO_LAST) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      bit_cnt_q <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign ps2clk_oe  = clk_oe_q;
  assign ps2data_oe = data_oe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_kbd_host_tx.sv
// Randomised bench for kbd_host_tx with an open-drain PS/2 device model and
// a frame reference built from the command byte with $countones parity.
module tb_kbd_host_tx;

  localparam int INH     = 40;
  localparam int TO      = 400;
  // 2-flop synchroniser + four low samples + FSM register
  localparam int DET_LAT = 7;

  logic       clk = 1'b0;
  logic       reset, send;
  logic [7:0] cmd;
  logic       ps2clk_oe, ps2data_oe, busy, done, error;
  logic       dev_clk, dev_data;
  logic       ps2clk_line, ps2data_line;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, busy_bad = 0;
  int inh_run = 0, inh_len = 0, inh_cnt = 0;
  logic last_doe = 1'b0, inh_last_doe = 1'b0;

  assign ps2clk_line  = dev_clk & ~ps2clk_oe;
  assign ps2data_line = dev_data & ~ps2data_oe;

  always #5 clk = ~clk;

  kbd_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2clk    (ps2clk_line),
    .ps2data   (ps2data_line),
    .ps2clk_oe (ps2clk_oe),
    .ps2data_oe(ps2data_oe),
    .cmd       (cmd),
    .send      (send),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  // Pulse counters and inhibit-window measurement.
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (error) err_cnt <= err_cnt + 1;
    if (done && error) both_cnt <= both_cnt + 1;
    if ((done || error) && busy) busy_bad <= busy_bad + 1;
    if (ps2clk_oe) begin
      inh_run  <= inh_run + 1;
      last_doe <= ps2data_oe;
    end else if (inh_run != 0) begin
      inh_len      <= inh_run;
      inh_last_doe <= last_doe;
      inh_cnt      <= inh_cnt + 1;
      inh_run      <= 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] model_frame(input logic [7:0] c);
    int ones;
    ones = $countones(c);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, c};
  endfunction

  // Device side: wait for request-to-send, clock n_edges falling edges, read bits.
  task automatic device_frame(input int n_edges, input logic ack_val,
                              output logic [9:0] bits, output bit started);
    int t;
    int hp;
    bits = '0;
    t = 0;
    while (!(ps2clk_line && !ps2data_line) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    started = (t < 20000);
    repeat ($urandom_range(12, 30)) @(negedge clk);
    for (int i = 0; i < n_edges; i++) begin
      hp = $urandom_range(15, 30);
      if (i == 10) dev_data = ack_val;
      dev_clk = 1'b0;
      repeat (hp) @(negedge clk);
      if (i < 10) bits[i] = ps2data_line;
      dev_clk = 1'b1;
      repeat (hp) @(negedge clk);
      if (i == 10) dev_data = 1'b1;
    end
  endtask

  task automatic run_txn(input logic [7:0] c, input logic ack_val, input bit extra,
                         input int exp_done, input int exp_err);
    logic [9:0] bits;
    bit started;
    int t, d0, e0, f0;
    d0 = done_cnt;
    e0 = err_cnt;
    f0 = inh_cnt;
    cmd = c;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    cmd = 8'h00;
    check_eq("busy_after_send", 32'(busy), 32'd1);
    if (extra) begin
      repeat (5) @(negedge clk);
      cmd = ~c;
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
    end
    device_frame(11, ack_val, bits, started);
    check_eq("start_bit", 32'(started), 32'd1);
    check_eq("frame", 32'(bits), 32'(model_frame(c)));
    check_eq("inhibit_len", inh_len, INH);
    check_eq("inhibit_last_data", 32'(inh_last_doe), 32'd1);
    t = 0;
    while (done_cnt == d0 && err_cnt == e0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check_eq("done_count", done_cnt - d0, exp_done);
    check_eq("error_count", err_cnt - e0, exp_err);
    check_eq("busy_idle", 32'(busy), 32'd0);
    check_eq("oe_idle", 32'({ps2clk_oe, ps2data_oe}), 32'd0);
    if (extra) begin
      repeat (60) @(negedge clk);
      check_eq("single_frame", inh_cnt - f0, 1);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] bits;
    bit started;
    logic [7:0] c;
    int n, d0;
    reset = 1'b1;
    send = 1'b0;
    cmd = 8'h00;
    dev_clk = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_clk_oe", 32'(ps2clk_oe), 32'd0);
    check_eq("rst_data_oe", 32'(ps2data_oe), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    run_txn(8'hED, 1'b0, 1'b0, 1, 0);
    run_txn(8'hF4, 1'b0, 1'b0, 1, 0);
    for (int k = 0; k < 6; k++) begin
      c = 8'($urandom());
      run_txn(c, 1'b0, 1'b0, 1, 0);
    end

    // Device NACK
`ifdef KBD_TX_ACK_CHECK_EN
    run_txn(8'hA5, 1'b1, 1'b0, 0, 1);
`else
    run_txn(8'hA5, 1'b1, 1'b0, 1, 0);
`endif

    // Second send while busy
    run_txn(8'h3A, 1'b0, 1'b1, 1, 0);

    // Device stops clocking after four edges
    d0 = done_cnt;
    cmd = 8'h12;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    device_frame(3, 1'b1, bits, started);
    dev_clk = 1'b0;
    n = 0;
    while (!error && n < TO + 100) begin
      @(negedge clk);
      n++;
      if (n == 20) dev_clk = 1'b1;
    end
    check_eq("timeout_latency", n, TO + DET_LAT);
    check_eq("timeout_clk_oe", 32'(ps2clk_oe), 32'd0);
    check_eq("timeout_data_oe", 32'(ps2data_oe), 32'd0);
    repeat (5) @(negedge clk);
    check_eq("timeout_no_done", done_cnt - d0, 0);
    check_eq("timeout_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);

    // Reset in the middle of SHIFT
    cmd = 8'h00;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    device_frame(5, 1'b1, bits, started);
    check_eq("pre_reset_data_oe", 32'(ps2data_oe), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("reset_clk_oe", 32'(ps2clk_oe), 32'd0);
    check_eq("reset_data_oe", 32'(ps2data_oe), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    run_txn(8'h55, 1'b0, 1'b0, 1, 0);

    repeat (5) @(negedge clk);
    check_eq("done_error_overlap", both_cnt, 0);
    check_eq("busy_at_pulse", busy_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kbd_host_tx.md
KBD_HOST_TX -- requirements
Module: kbd_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, clk cycles ps2clk is held low before the start bit (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 750000, max clk cycles between device falling edges, or spent waiting for line idle, before abort (15 ms at 50 MHz).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ps2clk  input  1  raw PS/2 clock line, asynchronous.
REQ-006 SHALL have port ps2data  input  1  raw PS/2 data line, asynchronous.
REQ-007 SHALL have port ps2clk_oe  output  1  1 = drive PS/2 clock low; 0 = release (pull-up).
REQ-008 SHALL have port ps2data_oe  output  1  1 = drive PS/2 data low; 0 = release.
REQ-009 SHALL have port cmd  input  8  command byte to transmit, e.g. 0xED set-LEDs.
REQ-010 SHALL have port send  input  1  one-cycle request; cmd is sampled on the same cycle.
REQ-011 SHALL have port busy  output  1  high from the cycle after an accepted send until done or error pulses.
REQ-012 SHALL have port done  output  1  one-cycle pulse on successful completion.
REQ-013 SHALL have port error  output  1  one-cycle pulse on timeout or NACK.

Function
REQ-014 SHALL synchronise ps2clk through an 8-sample shift register; a falling edge is older 4 samples = 4'hF and newer 4 samples = 4'h0.
REQ-015 SHALL implement FSM IDLE -> INHIBIT -> START -> SHIFT -> ACK -> WAIT_IDLE -> IDLE.
REQ-016 IDLE: send=1 SHALL latch cmd, compute odd parity (~^cmd), load the 10-bit frame {1 stop, parity, cmd} and go to INHIBIT; send while busy SHALL be ignored.
REQ-017 INHIBIT: ps2clk_oe=1 for INHIBIT_CYCLES cycles, with ps2data_oe asserted during the last cycle, then go to START.
REQ-018 START: ps2clk_oe=0, ps2data_oe=1 (start bit 0); clear the bit counter and the timeout counter; go to SHIFT.
REQ-019 SHIFT: on each detected falling edge, drive frame LSB first (ps2data_oe = ~bit), shift right, increment counter; after the 10th edge (stop bit released) go to ACK.
REQ-020 ACK: on the next falling edge, sample synchronised ps2data; 0 = ACK, go to WAIT_IDLE; 1 = NACK.
REQ-021 WAIT_IDLE: wait until synchronised ps2clk and ps2data are both high, then pulse done, go to IDLE.
REQ-022 The timeout counter SHALL reset on every detected falling edge and on entry to WAIT_IDLE; if it reaches TIMEOUT_CYCLES in SHIFT, ACK or WAIT_IDLE, SHALL pulse error, release both lines, go to IDLE.
REQ-023 done and error SHALL never assert in the same cycle; busy SHALL deassert in the cycle done or error pulses.
REQ-024 Outside INHIBIT/START/SHIFT both oe outputs SHALL be 0.
REQ-025 Counters SHALL be sized with $clog2 of their parameters and SHALL NOT wrap.

Reset
REQ-026 On reset: state IDLE, ps2clk_oe=0, ps2data_oe=0, busy=0, done=0, error=0, sample register 8'hFF, counters 0.
REQ-027 Reset mid-transfer SHALL release both lines in the next cycle and discard the command.

Configuration
REQ-028 With KBD_TX_ACK_CHECK_EN defined, NACK SHALL pulse error and go to IDLE.
REQ-029 Without KBD_TX_ACK_CHECK_EN, the ACK-state sample SHALL be ignored and the block SHALL always proceed to WAIT_IDLE.

Structure
REQ-030 Package kbd_pkg SHALL hold the FSM state typedef, PS2_FRAME_BITS = 10 and an odd-parity function.
REQ-031 Sub-module ps2_edge_sync SHALL contain the ps2clk/ps2data synchronisers and the falling-edge detector.

Verification
REQ-032 send cmd=0xED, device model ACKs -> bits on data lines 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses; busy low after.
REQ-033 send cmd=0xF4 -> parity bit 0; ps2clk_oe high for exactly INHIBIT_CYCLES cycles before the start bit.
REQ-034 Device stops clocking after 4 edges -> error pulses TIMEOUT_CYCLES after the last edge; both oe outputs 0.
REQ-035 Device NACK (data high on 11th edge) -> error pulses with KBD_TX_ACK_CHECK_EN defined; done pulses without it.
REQ-036 reset asserted mid-SHIFT -> both oe outputs 0 next cycle; a new send of 0x55 then completes normally.
REQ-037 Second send while busy -> ignored; exactly one frame is transmitted.
